// File: rtl/mcycle_sequencer.sv
// -----------------------------------------------------------------------------
// mcycle_sequencer
//
// Machine-cycle / T-state sequencer for the CPU core. Steps T1..T4 inside each
// M-cycle and M1..Mn inside each instruction. Latches the fetched opcode and
// produces the instruction-boundary strobe (m1t1), the register-file write
// window (wb_slot), the end-of-instruction flag (instr_done) and the HALT
// status.
//
// Ports:
//   clk          system clock, rising-edge active
//   rst          asynchronous reset, active low
//   op_next      opcode byte from the bus, captured at the M1 T3->T4 edge
//   mcycles      instruction length from the decoder, captured at M1 T4->T1
//   decode_valid qualifies mcycles (0 -> length of 1)
//   halt_req     current instruction is HALT, honoured only at the final T4
//   wake         interrupt pending, leaves HALT / suppresses HALT entry
//   wait_n       memory wait (active low), honoured only with the macro below
//   tstate       0..3 = T1..T4
//   mcycle       0-based M-cycle index (0 = M1)
//   m1t1         high for the T1 clock of M1
//   opcode       latched opcode
//   op_strobe    one-clock pulse in M1 T4
//   wb_slot      high in T4 of every M-cycle
//   instr_done   high in T4 of the final M-cycle
//   halted       high while in HALT
//
// Build option:
//   GB_WAIT_STATE_EN  when defined, wait_n=0 sampled in T2 holds the
//                     sequencer in T2 for one more clock.
// -----------------------------------------------------------------------------
module mcycle_sequencer #(
    parameter int MCYCLE_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          op_next,
    input  logic [MCYCLE_W-1:0] mcycles,
    input  logic                decode_valid,
    input  logic                halt_req,
    input  logic                wake,
    input  logic                wait_n,
    output logic [1:0]          tstate,
    output logic [MCYCLE_W-1:0] mcycle,
    output logic                m1t1,
    output logic [7:0]          opcode,
    output logic                op_strobe,
    output logic                wb_slot,
    output logic                instr_done,
    output logic                halted
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t              state_reg;
    logic [MCYCLE_W-1:0] len_reg;
    logic [MCYCLE_W-1:0] len_eff;
    logic [MCYCLE_W-1:0] last_m;
    logic                stall;

    // Effective length: an unqualified or zero length means a 1-M-cycle
    // instruction, so len-1 can never wrap.
    assign len_eff = (decode_valid && (mcycles != '0)) ? mcycles : MCYCLE_W'(1);

    // During M1 the length register still holds the previous instruction's
    // value, so the final-M-cycle test looks straight at the decoder output.
    // This also lets instr_done be registered for a 1-M-cycle instruction.
    assign last_m = (mcycle == '0) ? (len_eff - MCYCLE_W'(1))
                                   : (len_reg - MCYCLE_W'(1));

`ifdef GB_WAIT_STATE_EN
    assign stall = (tstate == 2'd1) && !wait_n;
`else
    // Port kept for interface stability; it has no effect in this build.
    logic wait_unused;
    assign wait_unused = wait_n;
    assign stall       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            len_reg    <= MCYCLE_W'(1);
            tstate     <= 2'd0;
            mcycle     <= '0;
            m1t1       <= 1'b0;
            opcode     <= 8'h00;
            op_strobe  <= 1'b0;
            wb_slot    <= 1'b0;
            instr_done <= 1'b0;
            halted     <= 1'b0;
        end else begin
            // Single-clock pulses clear unless re-armed below. During a
            // wait-state hold we are in T2, where all of them are already 0.
            m1t1       <= 1'b0;
            op_strobe  <= 1'b0;
            wb_slot    <= 1'b0;
            instr_done <= 1'b0;

            case (state_reg)
                IDLE: begin
                    state_reg <= RUN;
                    tstate    <= 2'd0;
                    mcycle    <= '0;
                    m1t1      <= 1'b1;
                    halted    <= 1'b0;
                end

                RUN: begin
                    if (!stall) begin
                        case (tstate)
                            2'd0: tstate <= 2'd1;
                            2'd1: tstate <= 2'd2;
                            2'd2: begin
                                // Entering T4: set up its registered flags.
                                tstate     <= 2'd3;
                                wb_slot    <= 1'b1;
                                instr_done <= (mcycle == last_m);
                                if (mcycle == '0) begin
                                    opcode    <= op_next;
                                    op_strobe <= 1'b1;
                                end
                            end
                            default: begin
                                // T4 -> T1: advance the M-cycle.
                                tstate <= 2'd0;
                                if (mcycle == '0) begin
                                    len_reg <= len_eff;
                                end
                                if (mcycle == last_m) begin
                                    mcycle <= '0;
                                    if (halt_req && !wake) begin
                                        state_reg <= HALT;
                                        halted    <= 1'b1;
                                    end else begin
                                        m1t1 <= 1'b1;
                                    end
                                end else begin
                                    mcycle <= mcycle + MCYCLE_W'(1);
                                end
                            end
                        endcase
                    end
                end

                HALT: begin
                    tstate <= 2'd0;
                    mcycle <= '0;
                    if (wake) begin
                        state_reg <= RUN;
                        halted    <= 1'b0;
                        m1t1      <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    halted    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcycle_sequencer.sv
`timescale 1ns/1ps
module tb_mcycle_sequencer;

    localparam int W = 3;

`ifdef GB_WAIT_STATE_EN
    localparam int WAIT_CLKS = 7;
`else
    localparam int WAIT_CLKS = 4;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [7:0]   op_next = 8'h00;
    logic [W-1:0] mcycles = '0;
    logic         decode_valid = 1'b0;
    logic         halt_req = 1'b0;
    logic         wake = 1'b0;
    logic         wait_n = 1'b1;
    logic [1:0]   tstate;
    logic [W-1:0] mcycle;
    logic         m1t1;
    logic [7:0]   opcode;
    logic         op_strobe;
    logic         wb_slot;
    logic         instr_done;
    logic         halted;

    mcycle_sequencer #(.MCYCLE_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .op_next      (op_next),
        .mcycles      (mcycles),
        .decode_valid (decode_valid),
        .halt_req     (halt_req),
        .wake         (wake),
        .wait_n       (wait_n),
        .tstate       (tstate),
        .mcycle       (mcycle),
        .m1t1         (m1t1),
        .opcode       (opcode),
        .op_strobe    (op_strobe),
        .wb_slot      (wb_slot),
        .instr_done   (instr_done),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    // Expected per-clock snapshot:
    // flags = {tstate, mcycle, m1t1, op_strobe, wb_slot, instr_done, halted}
    typedef struct {
        logic [9:0] flags;
        logic [7:0] op;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] cur_op   = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] observed();
        return {tstate, mcycle, m1t1, op_strobe, wb_slot, instr_done, halted};
    endfunction

    task automatic push_entry(input string tag, input logic [1:0] t, input logic [2:0] m,
                              input logic a, input logic s, input logic w, input logic d,
                              input logic h, input logic [7:0] op);
        sb.push_back('{flags: {t, m, a, s, w, d, h}, op: op, tag: tag});
    endtask

    task automatic compare_next();
        exp_t e;
        if (sb.size() == 0) begin
            check_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_eq({e.tag, "_flags"}, 32'(observed()), 32'(e.flags));
            check_eq({e.tag, "_opcode"}, 32'(opcode), 32'(e.op));
        end
    endtask

    // Expected trace of an instruction of length len: 4 clocks per M-cycle,
    // m1t1 in clock 0, opcode/op_strobe from clock 3, done in the last T4.
    task automatic push_instr(input string tag, input int len, input logic [7:0] op, input int nclk);
        for (int i = 0; i < nclk; i++) begin
            int t;
            int m;
            t = i % 4;
            m = i / 4;
            push_entry(tag, 2'(t), 3'(m), i == 0, i == 3, t == 3,
                       (t == 3) && (m == len - 1), 1'b0, (i >= 3) ? op : cur_op);
        end
        if (nclk >= 4) cur_op = op;
    endtask

    task automatic run_instr(input string tag, input int len, input logic [W-1:0] mc,
                             input logic dv, input logic [7:0] op,
                             input logic hr, input logic wk, input int nclk);
        push_instr(tag, len, op, nclk);
        for (int i = 0; i < nclk; i++) begin
            @(posedge clk); #1;
            compare_next();
            if (i == 0) begin
                mcycles      = mc;
                decode_valid = dv;
                op_next      = op;
            end
            if (i == 3) op_next = ~op;              // must not reach opcode
            if (i == 4) begin                       // length changes after M1
                mcycles      = W'(mc + 3'd3);
                decode_valid = ~dv;
            end
            halt_req = (i == nclk - 1) ? hr : i[0]; // noise off the final T4
            wake     = (i == nclk - 1) ? wk : 1'b0;
        end
        $display("instr %s len=%0d op=%02h clocks=%0d", tag, len, op, nclk);
    endtask

    task automatic run_halt(input string tag, input int n);
        for (int k = 0; k < n; k++)
            push_entry(tag, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cur_op);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            compare_next();
            halt_req = 1'b1;
            wake     = (k == n - 1);
        end
        $display("halt %s clocks=%0d", tag, n);
    endtask

    // Single 1-M-cycle instruction with wait_n low for the edges ending
    // clocks 1..3 (T2 when the instruction starts).
    task automatic run_wait(input string tag, input logic [7:0] op);
        for (int i = 0; i < WAIT_CLKS; i++) begin
            int t;
            t = (i == 0) ? 0 : (i <= WAIT_CLKS - 3) ? 1 : (i == WAIT_CLKS - 2) ? 2 : 3;
            push_entry(tag, 2'(t), 3'd0, i == 0, t == 3, t == 3, t == 3, 1'b0,
                       (t == 3) ? op : cur_op);
        end
        cur_op = op;
        for (int i = 0; i < WAIT_CLKS; i++) begin
            @(posedge clk); #1;
            compare_next();
            if (i == 0) begin
                mcycles      = 3'd1;
                decode_valid = 1'b1;
                op_next      = op;
            end
            wait_n   = (i >= 1 && i <= 3) ? 1'b0 : 1'b1;
            halt_req = 1'b0;
            wake     = 1'b0;
        end
        wait_n = 1'b1;
        $display("instr %s len=1 op=%02h clocks=%0d", tag, op, WAIT_CLKS);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check_eq("reset_outputs", 32'({observed(), opcode}), 32'd0);
        rst = 1'b1;
        $display("reset released");

        run_instr("len1_a", 1, 3'd1, 1'b1, 8'h00, 1'b0, 1'b0, 4);
        run_instr("len1_b", 1, 3'd1, 1'b1, 8'h11, 1'b0, 1'b0, 4);
        run_instr("len2_3e", 2, 3'd2, 1'b1, 8'h3E, 1'b0, 1'b0, 8);
        run_instr("dv0_mc5", 1, 3'd5, 1'b0, 8'h47, 1'b0, 1'b0, 4);
        run_instr("mc0", 1, 3'd0, 1'b1, 8'h5A, 1'b0, 1'b0, 4);
        run_instr("len7", 7, 3'd7, 1'b1, 8'hC3, 1'b0, 1'b0, 28);
        run_instr("len3", 3, 3'd3, 1'b1, 8'h21, 1'b0, 1'b0, 12);

        // HALT entry, 10 clocks in HALT, wake on the last of them
        run_instr("halt_in", 1, 3'd1, 1'b1, 8'h76, 1'b1, 1'b0, 4);
        run_halt("halted", 10);
        run_instr("after_wake", 2, 3'd2, 1'b1, 8'h01, 1'b0, 1'b0, 8);

        // halt_req and wake together: HALT skipped
        run_instr("halt_wake", 2, 3'd2, 1'b1, 8'h76, 1'b1, 1'b1, 8);
        run_instr("no_halt", 1, 3'd1, 1'b1, 8'h02, 1'b0, 1'b0, 4);

        run_wait("wait_t2", 8'h9B);
        run_instr("post_wait", 1, 3'd1, 1'b1, 8'h0F, 1'b0, 1'b0, 4);

        // Asynchronous reset during M2 T3 of a 3-M-cycle instruction
        run_instr("rst_mid", 3, 3'd3, 1'b1, 8'hA5, 1'b0, 1'b0, 7);
        #3 rst = 1'b0;
        #1 check_eq("async_rst_now", 32'({observed(), opcode}), 32'd0);
        @(posedge clk); #1;
        check_eq("async_rst_held", 32'({observed(), opcode}), 32'd0);
        rst      = 1'b1;
        cur_op   = 8'h00;
        halt_req = 1'b0;
        $display("reset mid-instruction released");
        run_instr("fresh_m1", 2, 3'd2, 1'b1, 8'hE9, 1'b0, 1'b0, 8);

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
